// File: rtl/mrd_rd_sched_p.sv
// Multi-bank read scheduler: maps lane addresses onto RAM banks, issues
// bank reads, steers returned data per lane into a credit-guarded output FIFO.
// Optional macro: MRD_RD_SCHED_CONFLICT_CHK_EN enables the sticky bank
// conflict flag (conflict_err tied low otherwise).
// Ports: clk/rst_n (async active-low); start/cnt_stop start a pass;
// addr_valid/addr_ready/addrs/lane_en take butterfly reads; ram_* is the
// bank read port; out_valid/out_ready/out_* deliver per-lane data; rd_end
// pulses at end of pass; busy = not idle.
module mrd_rd_sched_p #(
    parameter int NBANK      = 7,
    parameter int NLANE      = 5,
    parameter int DW         = 18,
    parameter int AW_LIN     = 12,
    parameter int WADDR      = 9,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int BIW       = $clog2(NBANK + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [11:0]                       cnt_stop,
    input  logic                              addr_valid,
    output logic                              addr_ready,
    input  logic [NLANE-1:0][AW_LIN-1:0]      addrs,
    input  logic [NLANE-1:0]                  lane_en,
    output logic [NBANK-1:0]                  ram_rden,
    output logic [NBANK-1:0][WADDR-1:0]       ram_rdaddr,
    input  logic [NBANK-1:0][DW-1:0]          ram_dout_real,
    input  logic [NBANK-1:0][DW-1:0]          ram_dout_imag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NLANE-1:0][DW-1:0]          out_real,
    output logic [NLANE-1:0][DW-1:0]          out_imag,
    output logic [NLANE-1:0][BIW-1:0]         out_bank_index,
    output logic [NLANE-1:0][WADDR-1:0]       out_bank_addr,
    output logic                              rd_end,
    output logic                              busy,
    output logic                              conflict_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_DRAIN} state_t;

    state_t      state_q;
    logic [12:0] issued_q;
    logic [12:0] target_q;
    logic        rd_end_q;

    logic [NLANE-1:0][BIW-1:0]   l_bank;
    logic [NLANE-1:0][WADDR-1:0] l_baddr;
    logic [NBANK-1:0]            bk_rden;
    logic [NBANK-1:0][WADDR-1:0] bk_addr;

    logic [RD_LAT:0]             s_v_q;
    logic [NLANE-1:0][BIW-1:0]   s_bank_q  [RD_LAT+1];
    logic [NLANE-1:0][WADDR-1:0] s_baddr_q [RD_LAT+1];
    logic [NBANK-1:0]            rden_q;
    logic [NBANK-1:0][WADDR-1:0] rdaddr_q;

    logic [NLANE-1:0][DW-1:0]    f_real [FIFO_DEPTH];
    logic [NLANE-1:0][DW-1:0]    f_imag [FIFO_DEPTH];
    logic [NLANE-1:0][BIW-1:0]   f_bi   [FIFO_DEPTH];
    logic [NLANE-1:0][WADDR-1:0] f_ba   [FIFO_DEPTH];
    logic [PW-1:0]               wr_q;
    logic [PW-1:0]               rd_q;
    logic [PW:0]                 count_q;
    logic [PW:0]                 count_d;

    logic [NLANE-1:0][DW-1:0]    push_real;
    logic [NLANE-1:0][DW-1:0]    push_imag;
    logic [CW-1:0]               inflight;
    logic                        accept;
    logic                        push;
    logic                        pop;
    logic                        drain_done;

    // Lane decode; disabled lanes get the invalid (all-ones) bank index.
    always_comb begin
        for (int l = 0; l < NLANE; l++) begin
            if (lane_en[l]) begin
                l_bank[l]  = BIW'(addrs[l] % AW_LIN'(NBANK));
                l_baddr[l] = WADDR'(addrs[l] / AW_LIN'(NBANK));
            end else begin
                l_bank[l]  = '1;
                l_baddr[l] = '0;
            end
        end
    end

    // Scan lanes high to low so the lowest lane on a shared bank wins.
    always_comb begin
        bk_rden = '0;
        bk_addr = '0;
        for (int b = 0; b < NBANK; b++) begin
            for (int l = NLANE - 1; l >= 0; l--) begin
                if (lane_en[l] && l_bank[l] == BIW'(b)) begin
                    bk_rden[b] = 1'b1;
                    bk_addr[b] = l_baddr[l];
                end
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= RD_LAT; k++)
            inflight = inflight + CW'(s_v_q[k]);
    end

    assign addr_ready = (state_q == S_RD) &&
                        ((inflight + CW'(count_q)) < CW'(FIFO_DEPTH));
    assign accept     = addr_valid && addr_ready;
    assign push       = s_v_q[RD_LAT];
    assign pop        = out_valid && out_ready;
    assign count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // Done once nothing remains upstream of the push stage and the FIFO
    // empties on this edge.
    assign drain_done = (s_v_q[RD_LAT-1:0] == '0) && (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            target_q <= '0;
            rd_end_q <= 1'b0;
        end else begin
            rd_end_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RD;
                        issued_q <= '0;
                        target_q <= (cnt_stop == 12'd0) ? 13'd4096
                                                        : {1'b0, cnt_stop};
                    end
                end
                S_RD: begin
                    if (accept) begin
                        issued_q <= issued_q + 13'd1;
                        if (issued_q + 13'd1 == target_q)
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q  <= S_IDLE;
                        rd_end_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_v_q    <= '0;
            rden_q   <= '0;
            rdaddr_q <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                s_bank_q[k]  <= '0;
                s_baddr_q[k] <= '0;
            end
        end else begin
            s_v_q        <= {s_v_q[RD_LAT-1:0], accept};
            s_bank_q[0]  <= l_bank;
            s_baddr_q[0] <= l_baddr;
            for (int k = 1; k <= RD_LAT; k++) begin
                s_bank_q[k]  <= s_bank_q[k-1];
                s_baddr_q[k] <= s_baddr_q[k-1];
            end
            rden_q   <= accept ? bk_rden : '0;
            rdaddr_q <= accept ? bk_addr : '0;
        end
    end

    always_comb begin
        push_real = '0;
        push_imag = '0;
        for (int l = 0; l < NLANE; l++) begin
            for (int b = 0; b < NBANK; b++) begin
                if (s_bank_q[RD_LAT][l] == BIW'(b)) begin
                    push_real[l] = ram_dout_real[b];
                    push_imag[l] = ram_dout_imag[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_real[wr_q] <= push_real;
            f_imag[wr_q] <= push_imag;
            f_bi[wr_q]   <= s_bank_q[RD_LAT];
            f_ba[wr_q]   <= s_baddr_q[RD_LAT];
        end
    end

    assign out_valid      = (count_q != '0);
    assign out_real       = out_valid ? f_real[rd_q] : '0;
    assign out_imag       = out_valid ? f_imag[rd_q] : '0;
    assign out_bank_index = out_valid ? f_bi[rd_q]   : '0;
    assign out_bank_addr  = out_valid ? f_ba[rd_q]   : '0;
    assign ram_rden       = rden_q;
    assign ram_rdaddr     = rdaddr_q;
    assign rd_end         = rd_end_q;
    assign busy           = (state_q != S_IDLE);

`ifdef MRD_RD_SCHED_CONFLICT_CHK_EN
    logic conf;
    logic conf_q;

    always_comb begin
        conf = 1'b0;
        for (int l = 0; l < NLANE; l++)
            for (int m = l + 1; m < NLANE; m++)
                if (lane_en[l] && lane_en[m] && l_bank[l] == l_bank[m])
                    conf = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conf_q <= 1'b0;
        else if (state_q == S_IDLE && start)
            conf_q <= 1'b0;
        else if (accept && conf)
            conf_q <= 1'b1;
    end

    assign conflict_err = conf_q;
`else
    assign conflict_err = 1'b0;
`endif

endmodule

// File: doc/mrd_rd_sched_p.md
MRD_RD_SCHED_P -- requirements
Module: mrd_rd_sched_p

Interface
REQ-001 SHALL have parameter NBANK, default 7: number of RAM banks.
REQ-002 SHALL have parameter NLANE, default 5: butterfly lanes per read (1..NBANK).
REQ-003 SHALL have parameter DW, default 18: real/imag sample width.
REQ-004 SHALL have parameter AW_LIN, default 12: linear address width.
REQ-005 SHALL have parameter WADDR, default 9: bank address width.
REQ-006 SHALL have parameter RD_LAT, default 2: RAM read latency in cycles.
REQ-007 SHALL have parameter FIFO_DEPTH, default 8: output buffer entries (power of 2, >= RD_LAT+2).
REQ-008 SHALL have port clk  in  1  sole clock, rising edge.
REQ-009 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-010 SHALL have port start  in  1  one-cycle pulse that begins a read pass.
REQ-011 SHALL have port cnt_stop  in  12  butterfly reads in the pass (0 means 4096).
REQ-012 SHALL have ports addr_valid in 1 / addr_ready out 1: address handshake.
REQ-013 SHALL have port addrs  in  NLANE x AW_LIN  linear lane addresses.
REQ-014 SHALL have port lane_en  in  NLANE  lane enable mask.
REQ-015 SHALL have ports ram_rden out NBANK, and ram_rdaddr out NBANK x WADDR.
REQ-016 SHALL have ports ram_dout_real in NBANK x DW, and ram_dout_imag in NBANK x DW.
REQ-017 SHALL have ports out_valid out 1 / out_ready in 1: output handshake.
REQ-018 SHALL have ports out_real, out_imag out NLANE x DW; out_bank_index out NLANE x BIW, where BIW = $clog2(NBANK+1); out_bank_addr out NLANE x WADDR.
REQ-019 SHALL have ports rd_end out 1, busy out 1, conflict_err out 1.

Function
REQ-020 SHALL derive bank = addr mod NBANK and bank_addr = addr / NBANK (truncated to WADDR) per lane.
REQ-021 SHALL encode a disabled lane as bank index all-ones (invalid), with zero data and zero address.
REQ-022 SHALL implement FSM IDLE -> RD on start; RD -> DRAIN when issued count == cnt_stop; DRAIN -> IDLE when in-flight == 0 and FIFO empty.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive addr_ready = (state==RD) && (inflight + fifo_count < FIFO_DEPTH).
REQ-025 SHALL count a butterfly read as accepted on addr_valid && addr_ready.
REQ-026 SHALL, for an acceptance at cycle T, register ram_rden/ram_rdaddr at T+1 for every bank hit by an enabled lane, with all other banks having rden=0 and rdaddr=0.
REQ-027 SHALL, on two enabled lanes hitting the same bank, let the lowest lane index drive rdaddr.
REQ-028 SHALL capture bank data at T+1+RD_LAT, steer it per lane by bank index into the FIFO, and present it at the FIFO head no earlier than T+2+RD_LAT.
REQ-029 SHALL hold out_* stable while out_valid && !out_ready; SHALL pop on out_valid && out_ready.
REQ-030 SHALL never overflow the FIFO, guaranteed by the credit rule in REQ-024.
REQ-031 SHALL pulse rd_end for one cycle on the DRAIN -> IDLE transition.
REQ-032 SHALL drive busy = (state != IDLE).
REQ-033 SHALL, on simultaneous push and pop at full, keep the count unchanged.

Reset
REQ-034 SHALL, while rst_n is low, immediately clear: state=IDLE, counters, in-flight pipeline, FIFO pointers, ram_rden=0, ram_rdaddr=0, out_valid=0, out data/index/addr=0, rd_end=0, conflict_err=0.
REQ-035 SHALL discard all in-flight and buffered data on reset mid-pass, with no rd_end.

Configuration
REQ-036 SHALL, when MRD_RD_SCHED_CONFLICT_CHK_EN is defined, set sticky conflict_err on an accepted read where two enabled lanes share a bank, cleared only by reset or start.
REQ-037 SHALL, when MRD_RD_SCHED_CONFLICT_CHK_EN is undefined, tie conflict_err to 0 and include no detection logic; REQ-027 still applies.

Verification
REQ-038 SHALL cover: defaults, cnt_stop=1, addrs={0,1,2,3,4}, all lanes enabled, out_ready=1 -> ram_rden=7'b0011111, rdaddr=0 at T+1; out_valid at T+4 with banks 0..4; rd_end one cycle later.
REQ-039 SHALL cover: addrs={15,22,29,36,43}, lane_en=5'b00111 -> banks 1,1,1 at addr 2,3,4; lane0 wins, rdaddr[1]=2; conflict_err=1 with macro, 0 without.
REQ-040 SHALL cover: cnt_stop=20, out_ready=0 throughout -> exactly 8 acceptances, then addr_ready=0; out_ready=1 -> all 20 delivered in order, rd_end after the last.
REQ-041 SHALL cover: lane_en=5'b00011 -> lanes 2..4 show index all-ones and zero data.
REQ-042 SHALL cover: rst_n low during RD after 3 acceptances -> outputs zero at once; restart with start yields a clean pass and no stale data.
REQ-043 SHALL cover: start pulse while busy -> ignored; issued count unaffected.
